// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard and forwarding controller for a five-stage (F/D/E/M/W) pipeline.
//   It keeps a shadow copy of the destination and control bits for the E, M
//   and W stages. From that shadow state it drives the forwarding selects,
//   the Decode bypass, the stalls and the flushes. Loads can occupy M for
//   MEM_LATENCY cycles.
//
// Parameters
//   AW          register address width
//   ZERO_REG    1: register 0 is hardwired (never forwarded, never stalls)
//   MEM_LATENCY cycles a load spends in M (1..4)
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   rs_d, rt_d, uses_rs_d/rt_d    Decode source registers and read enables
//   dst_d, reg_write_d            Decode destination and write enable
//   mem_to_reg_d                  Decode instruction is a load
//   pc_src_e                      branch/jump in Execute is taken
//   stall_f/d/e/m                 hold PC, F/D, D/E, E/M
//   flush_d/e/w                   clear F/D, D/E, M/W
//   fwd_a_e, fwd_b_e              00 regfile, 01 ResultW, 10 ALUOutM
//   byp_a_d, byp_b_d              Decode reads ResultW for rs/rt
module hazard_fwd_unit #(
    parameter int AW          = 5,
    parameter int ZERO_REG    = 1,
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic          uses_rs_d,
    input  logic          uses_rt_d,
    input  logic [AW-1:0] dst_d,
    input  logic          reg_write_d,
    input  logic          mem_to_reg_d,
    input  logic          pc_src_e,
    output logic          stall_f,
    output logic          stall_d,
    output logic          stall_e,
    output logic          stall_m,
    output logic          flush_d,
    output logic          flush_e,
    output logic          flush_w,
    output logic [1:0]    fwd_a_e,
    output logic [1:0]    fwd_b_e,
    output logic          byp_a_d,
    output logic          byp_b_d
);

    localparam logic       MULTI_CYCLE = (MEM_LATENCY > 1);
    localparam logic [1:0] MCNT_INIT   = 2'(MEM_LATENCY - 1);

    // shadow E
    logic          valid_e, reg_write_e, mem_to_reg_e, uses_rs_e, uses_rt_e;
    logic [AW-1:0] dst_e, rs_e, rt_e;
    // shadow M
    logic          valid_m, reg_write_m, mem_to_reg_m;
    logic [AW-1:0] dst_m;
    // shadow W (its load flag is never consulted, so it is not kept)
    logic          valid_w, reg_write_w;
    logic [AW-1:0] dst_w;
    // remaining memory-wait cycles of the load held in M
    logic [1:0]    mcnt;

    logic mem_stall, lu;

    function automatic logic match(input logic [AW-1:0] x, input logic v,
                                   input logic rw, input logic [AW-1:0] d);
        return v && rw && (d == x) && !((ZERO_REG != 0) && (x == '0));
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src, input logic uses,
        input logic vm, input logic rwm, input logic ldm, input logic [AW-1:0] dm,
        input logic vw, input logic rww, input logic [AW-1:0] dw);
        if (!uses)                          return 2'b00;
        else if (match(src, vm, rwm, dm) && !ldm) return 2'b10;
        else if (match(src, vw, rww, dw))  return 2'b01;
        else                                return 2'b00;
    endfunction

    assign mem_stall = (mcnt != 2'd0);
    assign lu = valid_e && mem_to_reg_e &&
                ((uses_rs_d && match(rs_d, valid_e, reg_write_e, dst_e)) ||
                 (uses_rt_d && match(rt_d, valid_e, reg_write_e, dst_e)));

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        byp_a_d = 1'b0;
        byp_b_d = 1'b0;
        if (!reset) begin
            fwd_a_e = fwd_sel(rs_e, uses_rs_e, valid_m, reg_write_m, mem_to_reg_m, dst_m,
                              valid_w, reg_write_w, dst_w);
            fwd_b_e = fwd_sel(rt_e, uses_rt_e, valid_m, reg_write_m, mem_to_reg_m, dst_m,
                              valid_w, reg_write_w, dst_w);
            byp_a_d = uses_rs_d && match(rs_d, valid_w, reg_write_w, dst_w);
            byp_b_d = uses_rt_d && match(rt_d, valid_w, reg_write_w, dst_w);
            if (mem_stall) begin
                // branch stays in E and is re-evaluated after release
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e <= 1'b0;
            valid_m <= 1'b0;
            valid_w <= 1'b0;
            mcnt    <= 2'd0;
        end else if (mem_stall) begin
            valid_w <= 1'b0;
            mcnt    <= mcnt - 2'd1;
        end else begin
            valid_w      <= valid_m;
            reg_write_w  <= reg_write_m;
            dst_w        <= dst_m;
            valid_m      <= valid_e;
            reg_write_m  <= reg_write_e;
            mem_to_reg_m <= mem_to_reg_e;
            dst_m        <= dst_e;
            mcnt         <= (MULTI_CYCLE && valid_e && mem_to_reg_e) ? MCNT_INIT : 2'd0;
            if (pc_src_e || lu) begin
                valid_e      <= 1'b0;
                reg_write_e  <= 1'b0;
                mem_to_reg_e <= 1'b0;
                uses_rs_e    <= 1'b0;
                uses_rt_e    <= 1'b0;
            end else begin
                valid_e      <= 1'b1;
                reg_write_e  <= reg_write_d;
                mem_to_reg_e <= mem_to_reg_d;
                uses_rs_e    <= uses_rs_d;
                uses_rt_e    <= uses_rt_d;
                dst_e        <= dst_d;
                rs_e         <= rs_d;
                rt_e         <= rt_d;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit. Three instances share one stimulus stream:
//   0: ZERO_REG=1, MEM_LATENCY=1   1: ZERO_REG=1, MEM_LATENCY=3
//   2: ZERO_REG=0, MEM_LATENCY=1
// Expected output vectors are queued while driving and compared at negedge.
// Vector layout: {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w,
//                 fwd_a_e,fwd_b_e,byp_a_d,byp_b_d}
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, dst_d;
    logic       uses_rs_d, uses_rt_d, reg_write_d, mem_to_reg_d, pc_src_e;

    logic       sf0, sd0, se0, sm0, fd0, fe0, fw0, ba0, bb0;
    logic [1:0] fa0, fb0;
    logic       sf1, sd1, se1, sm1, fd1, fe1, fw1, ba1, bb1;
    logic [1:0] fa1, fb1;
    logic       sf2, sd2, se2, sm2, fd2, fe2, fw2, ba2, bb2;
    logic [1:0] fa2, fb2;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.AW(5), .ZERO_REG(1), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
        .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .dst_d(dst_d),
        .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .pc_src_e(pc_src_e),
        .stall_f(sf0), .stall_d(sd0), .stall_e(se0), .stall_m(sm0),
        .flush_d(fd0), .flush_e(fe0), .flush_w(fw0),
        .fwd_a_e(fa0), .fwd_b_e(fb0), .byp_a_d(ba0), .byp_b_d(bb0));

    hazard_fwd_unit #(.AW(5), .ZERO_REG(1), .MEM_LATENCY(3)) u_ml3 (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
        .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .dst_d(dst_d),
        .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .pc_src_e(pc_src_e),
        .stall_f(sf1), .stall_d(sd1), .stall_e(se1), .stall_m(sm1),
        .flush_d(fd1), .flush_e(fe1), .flush_w(fw1),
        .fwd_a_e(fa1), .fwd_b_e(fb1), .byp_a_d(ba1), .byp_b_d(bb1));

    hazard_fwd_unit #(.AW(5), .ZERO_REG(0), .MEM_LATENCY(1)) u_z0 (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
        .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .dst_d(dst_d),
        .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .pc_src_e(pc_src_e),
        .stall_f(sf2), .stall_d(sd2), .stall_e(se2), .stall_m(sm2),
        .flush_d(fd2), .flush_e(fe2), .flush_w(fw2),
        .fwd_a_e(fa2), .fwd_b_e(fb2), .byp_a_d(ba2), .byp_b_d(bb2));

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_MEM  = 7'b1111001;
    localparam logic [6:0] C_BR   = 7'b0000110;

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [12:0] pk(input logic [6:0] c, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic ba, input logic bb);
        return {c, fa, fb, ba, bb};
    endfunction

    function automatic logic [12:0] pick(input int unsigned sel);
        case (sel)
            0:       return {sf0, sd0, se0, sm0, fd0, fe0, fw0, fa0, fb0, ba0, bb0};
            1:       return {sf1, sd1, se1, sm1, fd1, fe1, fw1, fa1, fb1, ba1, bb1};
            default: return {sf2, sd2, se2, sm2, fd2, fe2, fw2, fa2, fb2, ba2, bb2};
        endcase
    endfunction

    task automatic want(input string tag, input int unsigned sel, input logic [12:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic want_all(input string tag, input logic [12:0] v);
        for (int unsigned s = 0; s < 3; s++) want(tag, s, v);
    endtask

    task automatic tick();
        exp_t        e;
        logic [12:0] got;
        @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = pick(e.sel);
            checks++;
            assert (got === e.v) else begin
                failures++;
                $error("FAIL %s dut%0d observed=%b expected=%b", e.tag, e.sel, got, e.v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic [4:0] dst, input logic rw,
                       input logic ld, input logic pc);
        rs_d = rs; rt_d = rt; uses_rs_d = urs; uses_rt_d = urt;
        dst_d = dst; reg_write_d = rw; mem_to_reg_d = ld; pc_src_e = pc;
    endtask

    task automatic nop();
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int unsigned n);
        reset = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            drv(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
            want_all("reset", pk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        nop();
        do_reset(3);

        // ALU forwarding from M then W
        drv(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);   want_all("first_no_dep", '0); tick();
        drv(5'd3, 5'd6, 1, 1, 5'd8, 1, 0, 0);   want_all("add_in_e", '0); tick();
        drv(5'd9, 5'd3, 1, 1, 5'd10, 1, 0, 0);  want_all("fwd_a_from_m", pk(C_NONE, 2'b10, 2'b00, 0, 0)); tick();
        nop();                                  want_all("fwd_b_from_w", pk(C_NONE, 2'b00, 2'b01, 0, 0)); tick();
        nop();                                  want_all("nop_in_e", '0); tick();

        // load-use: one bubble (and memory wait on the MEM_LATENCY=3 copy)
        drv(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);   want_all("lw_in_d", '0); tick();
        drv(5'd5, 5'd2, 1, 1, 5'd6, 1, 0, 0);   want_all("load_use", pk(C_LU, 2'b00, 2'b00, 0, 0)); tick();
        want("bubble_no_fwd", 0, '0);
        want("bubble_no_fwd", 2, '0);
        want("ml3_lu_then_wait", 1, pk(C_MEM, 2'b00, 2'b00, 0, 0)); tick();
        nop();
        want("lu_fwd_w", 0, pk(C_NONE, 2'b01, 2'b00, 0, 0));
        want("lu_fwd_w", 2, pk(C_NONE, 2'b01, 2'b00, 0, 0)); tick();

        // writes to r0
        drv(5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0);   want("add_r0", 0, '0); want("add_r0", 2, '0); tick();
        drv(5'd0, 5'd0, 1, 1, 5'd11, 1, 0, 0);  want("rd_r0_d", 0, '0); want("rd_r0_d", 2, '0); tick();
        nop();
        want("zr_fwd", 0, '0);
        want("nozr_fwd", 2, pk(C_NONE, 2'b10, 2'b10, 0, 0)); tick();
        drv(5'd0, 5'd0, 1, 0, 5'd12, 1, 0, 0);
        want("zr_byp", 0, '0);
        want("nozr_byp", 2, pk(C_NONE, 2'b00, 2'b00, 1, 0)); tick();
        drv(5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0);   want("lw_r0_d", 0, '0); want("lw_r0_d", 2, '0); tick();
        drv(5'd0, 5'd3, 1, 1, 5'd13, 1, 0, 0);
        want("zr_no_stall", 0, '0);
        want("nozr_lu", 2, pk(C_LU, 2'b00, 2'b00, 0, 0)); tick();

        do_reset(2);

        // W->D bypass, then load-use coinciding with a taken branch
        drv(5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0);   want_all("add_r7", '0); tick();
        nop();                                  want_all("p2_nop1", '0); tick();
        nop();                                  want_all("p2_nop2", '0); tick();
        drv(5'd8, 5'd7, 1, 1, 5'd9, 1, 0, 0);   want_all("byp_b", pk(C_NONE, 2'b00, 2'b00, 0, 1)); tick();
        drv(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);   want_all("p2_lw_d", '0); tick();
        drv(5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 1);   want_all("lu_vs_branch", pk(C_BR, 2'b00, 2'b00, 0, 0)); tick();
        nop();
        want("after_br", 0, '0);
        want("after_br", 2, '0);
        want("ml3_wait_after_br", 1, pk(C_MEM, 2'b00, 2'b00, 0, 0)); tick();

        do_reset(2);

        // MEM_LATENCY=3: two stall cycles, branch held then taken
        drv(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);   want("m_lw_d", 1, '0); tick();
        drv(5'd2, 5'd3, 1, 1, 5'd0, 0, 0, 0);   want("m_beq_d", 1, '0); tick();
        drv(5'd4, 5'd0, 1, 0, 5'd9, 1, 0, 1);   want("m_wait1", 1, pk(C_MEM, 2'b00, 2'b00, 0, 0)); tick();
                                                want("m_wait2", 1, pk(C_MEM, 2'b00, 2'b00, 0, 0)); tick();
                                                want("m_release_br", 1, pk(C_BR, 2'b00, 2'b00, 0, 0)); tick();
        nop();                                  want("m_after", 1, '0); tick();
        drv(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);   want("m_lw2_d", 1, '0); tick();
        nop();                                  want("m_lw2_e", 1, '0); tick();
                                                want("m_wait_again", 1, pk(C_MEM, 2'b00, 2'b00, 0, 0)); tick();
        reset = 1'b1;                           want("m_reset_mid", 1, '0); tick();
        reset = 1'b0;                           want("m_abort_stall", 1, '0); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
